// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the execute stage.
//               One shift-add multiply bit or one restoring-division quotient
//               bit is resolved per cycle, giving a fixed 32-cycle latency.
//               While an operation is running, the unit holds the fetch,
//               decode and decode/execute registers through a combinational
//               stall. The result and destination index are registered and
//               qualified by a one-cycle done pulse.
// Ports       : clk, rst (async, active-high)
//               start, flush, op[2:0] (funct3), rs1_data, rs2_data, rd_in
//               stall, done, result[31:0], rd_out[4:0]
// Options     : MULDIV_FAST_MUL_EN - when defined, the multiply ops use a
//               single-cycle combinational 64-bit product (IDLE -> DONE).
//               Division always uses the iterative path.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    // Registered state
    state_t      r_state_q,  w_state_d;
    logic [4:0]  r_cnt_q,    w_cnt_d;
    logic [2:0]  r_op_q,     w_op_d;
    logic [4:0]  r_rd_q,     w_rd_d;
    logic        r_neg_q,    w_neg_d;
    // Multiplicand for multiply, divisor for divide
    logic [31:0] r_opb_q,    w_opb_d;
    // Multiply: {product_hi, multiplier/product_lo}
    // Divide  : {partial remainder, dividend/quotient}
    logic [63:0] r_acc_q,    w_acc_d;
    logic [31:0] r_result_q, w_result_d;
    logic [4:0]  r_rd_out_q, w_rd_out_d;

    // ------------------------------------------------------------------------
    // Operand preparation at acceptance: magnitudes plus a single result-sign
    // flag, so the iterative core only ever works on unsigned values.
    // MUL is treated as signed x signed; its low half is identical either way.
    // ------------------------------------------------------------------------
    logic        w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_start_neg;
    logic [31:0] w_a_mag, w_b_mag;

    assign w_a_signed = (op == c_OP_MUL) || (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_b_signed = (op == c_OP_MUL) || (op == c_OP_MULH) ||
                        (op == c_OP_DIV) || (op == c_OP_REM);
    assign w_a_neg    = w_a_signed & rs1_data[31];
    assign w_b_neg    = w_b_signed & rs2_data[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - rs1_data) : rs1_data;
    assign w_b_mag    = w_b_neg ? (32'd0 - rs2_data) : rs2_data;

    always_comb begin
        w_start_neg = 1'b0;
        case (op[2:1])
            // Quotient sign is suppressed on divide-by-zero so the all-ones
            // quotient from the restoring loop passes through unchanged.
            2'b10:   w_start_neg = (w_a_neg ^ w_b_neg) & (rs2_data != 32'd0);
            // Remainder follows the dividend sign.
            2'b11:   w_start_neg = w_a_neg;
            default: w_start_neg = w_a_neg ^ w_b_neg;
        endcase
    end

    // ------------------------------------------------------------------------
    // One iteration step for each datapath.
    // ------------------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_div_rs;
    logic        w_div_ge;
    logic [63:0] w_div_step;
    logic [63:0] w_acc_step;

    assign w_mul_sum  = {1'b0, r_acc_q[63:32]} + (r_acc_q[0] ? {1'b0, r_opb_q} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc_q[31:1]};

    // Shifted partial remainder is 33 bits; the difference always fits in
    // 32 bits because it is smaller than the divisor.
    assign w_div_rs   = r_acc_q[63:31];
    assign w_div_ge   = (w_div_rs >= {1'b0, r_opb_q});
    assign w_div_step = {(w_div_ge ? (w_div_rs[31:0] - r_opb_q) : w_div_rs[31:0]),
                         r_acc_q[30:0], w_div_ge};

    assign w_acc_step = r_op_q[2] ? w_div_step : w_mul_step;

    // ------------------------------------------------------------------------
    // Result selection and sign correction.
    // ------------------------------------------------------------------------
    logic [63:0] w_fin_acc;
    logic [2:0]  w_fin_op;
    logic        w_fin_neg;
    logic [63:0] w_fin_neg_acc;
    logic [31:0] w_fin_result;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {32'd0, w_a_mag} * {32'd0, w_b_mag};
    // In IDLE the only result ever loaded is the single-cycle product.
    assign w_fin_acc   = (r_state_q == ST_IDLE) ? w_fast_prod : w_acc_step;
    assign w_fin_op    = (r_state_q == ST_IDLE) ? op          : r_op_q;
    assign w_fin_neg   = (r_state_q == ST_IDLE) ? w_start_neg : r_neg_q;
`else
    assign w_fin_acc   = w_acc_step;
    assign w_fin_op    = r_op_q;
    assign w_fin_neg   = r_neg_q;
`endif

    assign w_fin_neg_acc = 64'd0 - w_fin_acc;

    always_comb begin
        w_fin_result = 32'd0;
        case (w_fin_op)
            c_OP_MUL:
                w_fin_result = w_fin_neg ? w_fin_neg_acc[31:0] : w_fin_acc[31:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU:
                w_fin_result = w_fin_neg ? w_fin_neg_acc[63:32] : w_fin_acc[63:32];
            c_OP_DIV, c_OP_DIVU:
                w_fin_result = w_fin_neg ? (32'd0 - w_fin_acc[31:0]) : w_fin_acc[31:0];
            default:
                w_fin_result = w_fin_neg ? (32'd0 - w_fin_acc[63:32]) : w_fin_acc[63:32];
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_op_d     = r_op_q;
        w_rd_d     = r_rd_q;
        w_neg_d    = r_neg_q;
        w_opb_d    = r_opb_q;
        w_acc_d    = r_acc_q;
        w_result_d = r_result_q;
        w_rd_out_d = r_rd_out_q;

        case (r_state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_op_d    = op;
                    w_rd_d    = rd_in;
                    w_neg_d   = w_start_neg;
                    w_cnt_d   = 5'd0;
                    w_opb_d   = op[2] ? w_b_mag : w_a_mag;
                    w_acc_d   = {32'd0, (op[2] ? w_a_mag : w_b_mag)};
                    w_state_d = ST_RUN;
`ifdef MULDIV_FAST_MUL_EN
                    if (!op[2]) begin
                        w_state_d  = ST_DONE;
                        w_result_d = w_fin_result;
                        w_rd_out_d = rd_in;
                    end
`endif
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = 5'd0;
                end else begin
                    w_acc_d = w_acc_step;
                    w_cnt_d = r_cnt_q + 5'd1;
                    if (r_cnt_q == 5'd31) begin
                        w_state_d  = ST_DONE;
                        w_result_d = w_fin_result;
                        w_rd_out_d = r_rd_q;
                    end
                end
            end
            ST_DONE: begin
                // start is still the same instruction here and is ignored.
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= 5'd0;
            r_op_q     <= 3'd0;
            r_rd_q     <= 5'd0;
            r_neg_q    <= 1'b0;
            r_opb_q    <= 32'd0;
            r_acc_q    <= 64'd0;
            r_result_q <= 32'd0;
            r_rd_out_q <= 5'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_op_q     <= w_op_d;
            r_rd_q     <= w_rd_d;
            r_neg_q    <= w_neg_d;
            r_opb_q    <= w_opb_d;
            r_acc_q    <= w_acc_d;
            r_result_q <= w_result_d;
            r_rd_out_q <= w_rd_out_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign stall  = ((r_state_q == ST_IDLE) & start & ~flush) |
                    ((r_state_q == ST_RUN) & ~flush);
    // A flush in the DONE cycle kills the instruction, so it is not reported.
    assign done   = (r_state_q == ST_DONE) & ~flush;
    assign result = r_result_q;
    assign rd_out = r_rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit. Directed vector table,
//               random operations against a plain-arithmetic RV32M model, and
//               hand-written flush/reset/hold sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

`ifdef MULDIV_FAST_MUL_EN
    localparam int c_MUL_DONE_N = 1;
`else
    localparam int c_MUL_DONE_N = 33;
`endif
    localparam int c_DIV_DONE_N = 33;

    ex_muldiv_unit u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // RV32M behaviour from the instruction definitions, using 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : (a / b);
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : (a % b);
        endcase
    endfunction

    // Issue one operation, hold start through DONE, check latency/stall/result.
    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        int   n;
        logic seen;
        logic stall_bad;
        int   exp_n;
        exp_n = o[2] ? c_DIV_DONE_N : c_MUL_DONE_N;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_in = r; start = 1'b1;
        #1;
        chk({nm, "_stall_start"}, 32'(stall), 32'd1);
        n = 0; seen = 1'b0; stall_bad = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
            else if (stall !== 1'b1) stall_bad = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_done_cycle"}, 32'(n), 32'(exp_n));
        chk({nm, "_stall_run"}, 32'(stall_bad), 32'd0);
        chk({nm, "_stall_done"}, 32'(stall), 32'd0);
        chk({nm, "_result"}, result, exp);
        chk({nm, "_rd_out"}, 32'(rd_out), 32'(r));
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(done), 32'd0);
        start = 1'b0;
        #1;
        chk({nm, "_no_relaunch"}, 32'(stall), 32'd0);
        last_result = exp;
        last_rd     = r;
    endtask

    initial begin
        vec_t vecs[14];
        int   n;
        logic seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         5'd7,  32'h0000_000E};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         5'd8,  32'h0000_0002};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         5'd10, 32'h0000_0005};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000};
        vecs[12] = '{3'd0, 32'd6,         32'd7,         5'd13, 32'h0000_002A};
        vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         5'd31, 32'hFFFF_FFF9};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
        rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
        last_result = 32'd0; last_rd = 5'd0;

        // Reset state, and stall tracking start while reset is held.
        @(negedge clk); @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd_out", 32'(rd_out), 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        start = 1'b1;
        #1;
        chk("rst_stall_start", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), ro, ra, rb, 5'($urandom), ref_model(ro, ra, rb));
        end

        // flush has priority over start in IDLE
        @(negedge clk);
        op = 3'd5; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd20;
        start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_idle_not_run", 32'(stall), 32'd0);

        // flush at count=10: no done, result and rd_out held
        @(negedge clk);
        op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd7; rd_in = 5'd21; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_run_stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_done", 32'(seen), 32'd0);
        chk("flush_result_held", result, last_result);
        chk("flush_rd_held", 32'(rd_out), 32'(last_rd));
        run_op("after_flush_divu", 3'd5, 32'd9, 32'd3, 5'd22, 32'd3);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        op = 3'd5; rs1_data = 32'd77; rs2_data = 32'd4; rd_in = 5'd23; start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd_out", 32'(rd_out), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd1);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        chk("midrst_idle", 32'(stall), 32'd0);
        last_result = 32'd0; last_rd = 5'd0;

        // flush arriving in the DONE cycle suppresses done
        @(negedge clk);
        op = 3'd5; rs1_data = 32'd20; rs2_data = 32'd4; rd_in = 5'd24; start = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        chk("fdone_seen", 32'(seen), 32'd1);
        flush = 1'b1;
        #1;
        chk("fdone_done_killed", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("fdone_idle", 32'(stall), 32'd0);
        chk("fdone_no_done", 32'(done), 32'd0);

        // Follow-up operation still works
        run_op("final_mulhu", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd25,
               ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
